// File: rtl/sim_sram_pkg.sv
// Shared types and helpers for the simulation SRAM data port.
// Access sizes, byte-lane mask generation and the latency ceiling.
package sim_sram_pkg;

    localparam int MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Halfword masks shift out of the top lane rather than wrapping.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = 4'b0011 << addr_lo;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sram_resp_pipe.sv
// Fixed-latency response shift register carrying {valid, data}.
// The last stage drives the port's data_ok / rdata directly.
module sram_resp_pipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q [LATENCY];
    logic [WIDTH-1:0] data_q  [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data stages are cleared as well as the valids, so rdata reads 0 straight out of reset.
            for (int s = 0; s < LATENCY; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/sim_sram_port.sv
// Simulation data memory behind the req / addr_ok / data_ok handshake, with
// configurable latency, outstanding limit, periodic address stall and preload.
module sim_sram_port
    import sim_sram_pkg::*;
#(
    parameter int    DEPTH_LOG2      = 16,
    parameter int    LATENCY         = 1,
    parameter int    MAX_OUTSTANDING = 4,
    parameter int    STALL_PERIOD    = 0,
    parameter string INIT_FILE       = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("sim_sram_port: LATENCY out of range");
    end

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [CNT_W-1:0]      outstanding;
    logic [STALL_W-1:0]    stall_cnt;
    logic                  stall;
    logic                  accept;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            mask;
    logic [31:0]           resp_data;
    logic                  unused_addr_hi;

    assign word_idx       = data_addr[DEPTH_LOG2+1:2];
    assign unused_addr_hi = ^data_addr[31:DEPTH_LOG2+2];
    assign mask           = byte_mask(data_size, data_addr[1:0]);

    // Free-running phase counter; the last phase of each period blocks acceptance.
    always_ff @(posedge clk) begin
        if (rst || STALL_PERIOD == 0) begin
            stall_cnt <= '0;
        end else if (stall_cnt == STALL_W'(STALL_PERIOD - 1)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign stall        = (STALL_PERIOD > 0) && (stall_cnt == STALL_W'(STALL_PERIOD - 1));
    assign data_addr_ok = data_req && !rst && (outstanding < CNT_W'(MAX_OUTSTANDING)) && !stall;
    assign accept       = data_req && data_addr_ok;

    // Credits come back only on the edge after data_ok, never in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, data_data_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: the memory array is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) mem[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    assign resp_data = (accept && !data_wr) ? mem[word_idx] : 32'h0;

    sram_resp_pipe #(
        .LATENCY (LATENCY),
        .WIDTH   (32)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (resp_data),
        .out_valid (data_data_ok),
        .out_data  (data_rdata)
    );

endmodule
